// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states, datapath
// mux codes, ALU op classes and the RV32I major opcodes (mirrors opcodes.v).
package multicycle_control_unit_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_RS1    = 2'd1;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd2;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_BRANCH = 2'd1;
    localparam logic [1:0] ALU_FUNCT  = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
    localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD           = 7'b0000011;
    localparam logic [6:0] OP_STORE          = 7'b0100011;
    localparam logic [6:0] OP_BRANCH         = 7'b1100011;
    localparam logic [6:0] OP_JAL            = 7'b1101111;
    localparam logic [6:0] OP_JALR           = 7'b1100111;
    localparam logic [6:0] OP_ECALL          = 7'b1110011;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       i_or_d;
        logic       pc_source;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] wb_sel;
        logic       is_halted;
    } ctrl_t;

endpackage

// File: rtl/ctrl_perf_counters.sv
// Free-running cycle and retired-instruction counters for the control unit.
// Only instantiated when CTRL_PERF_CNT_EN is defined.
module ctrl_perf_counters (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        count_en,
    input  logic        retire,
    output logic [31:0] cycle_count,
    output logic [31:0] instret
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count <= '0;
            instret     <= '0;
        end else begin
            if (count_en) cycle_count <= cycle_count + 32'd1;
            if (retire)   instret     <= instret + 32'd1;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Sequencing FSM stepping each RV32I instruction through IF/ID/EX/MEM/WB.
// Define CTRL_PERF_CNT_EN to add cycle_count/instret performance counters.
import multicycle_control_unit_pkg::*;

module multicycle_control_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  opcode,
    input  logic        bcond,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        i_or_d,
    output logic        pc_source,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic        is_halted,
`ifdef CTRL_PERF_CNT_EN
    output logic [31:0] cycle_count,
    output logic [31:0] instret,
`endif
    output logic [2:0]  state
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl;

    // bcond only gates the datapath's PC write; the sequencing never looks at it.
    logic unused_bcond;
    assign unused_bcond = bcond;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= S_IF;
        else          state_reg <= state_next;
    end

    always_comb begin
        ctrl       = '0;
        state_next = state_reg;
        case (state_reg)
            S_IF: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_a = SRC_A_PC;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALU_ADD;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_next    = S_ID;
                end
            end
            S_ID: begin
                ctrl.alu_src_a = SRC_A_OLD_PC;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
                state_next     = (opcode == OP_ECALL) ? S_HALT : S_EX;
            end
            S_EX: begin
                state_next = S_IF;
                case (opcode)
                    OP_ARITHMETIC, OP_ARITHMETIC_IMM: begin
                        ctrl.alu_src_a = SRC_A_RS1;
                        ctrl.alu_src_b = (opcode == OP_ARITHMETIC) ? SRC_B_RS2 : SRC_B_IMM;
                        ctrl.alu_op    = ALU_FUNCT;
                        state_next     = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        ctrl.alu_src_a = SRC_A_RS1;
                        ctrl.alu_src_b = SRC_B_IMM;
                        ctrl.alu_op    = ALU_ADD;
                        state_next     = S_MEM;
                    end
                    OP_BRANCH: begin
                        ctrl.alu_src_a     = SRC_A_RS1;
                        ctrl.alu_src_b     = SRC_B_RS2;
                        ctrl.alu_op        = ALU_BRANCH;
                        ctrl.pc_write_cond = 1'b1;
                        ctrl.pc_source     = 1'b1;
                    end
                    OP_JAL: begin
                        // Target already sits in ALUOut from ID; rd takes the live PC.
                        ctrl.pc_write  = 1'b1;
                        ctrl.pc_source = 1'b1;
                        ctrl.reg_write = 1'b1;
                        ctrl.wb_sel    = WB_PC;
                    end
                    OP_JALR: begin
                        ctrl.alu_src_a = SRC_A_RS1;
                        ctrl.alu_src_b = SRC_B_IMM;
                        ctrl.alu_op    = ALU_ADD;
                        ctrl.pc_write  = 1'b1;
                        ctrl.reg_write = 1'b1;
                        ctrl.wb_sel    = WB_PC;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_read  = (opcode == OP_LOAD);
                ctrl.mem_write = (opcode == OP_STORE);
                if (mem_ready) state_next = (opcode == OP_LOAD) ? S_WB : S_IF;
            end
            S_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = (opcode == OP_LOAD) ? WB_MDR : WB_ALUOUT;
                state_next     = S_IF;
            end
            S_HALT: ctrl.is_halted = 1'b1;
            default: state_next = S_IF;
        endcase
        // Strobes must drop the instant reset asserts, not at the next edge.
        if (!reset_n) ctrl = '0;
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign ir_write      = ctrl.ir_write;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign reg_write     = ctrl.reg_write;
    assign i_or_d        = ctrl.i_or_d;
    assign pc_source     = ctrl.pc_source;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign wb_sel        = ctrl.wb_sel;
    assign is_halted     = ctrl.is_halted;
    assign state         = state_reg;

`ifdef CTRL_PERF_CNT_EN
    logic retire;
    assign retire = (state_reg == S_EX || state_reg == S_MEM || state_reg == S_WB)
                    && (state_next == S_IF);

    ctrl_perf_counters u_perf (
        .clk         (clk),
        .reset_n     (reset_n),
        .count_en    (state_reg != S_HALT),
        .retire      (retire),
        .cycle_count (cycle_count),
        .instret     (instret)
    );
`endif

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Sequencing FSM for the multi-cycle RV32I datapath. It replaces per-instruction combinational decoding with a state machine that steps each instruction through fetch, decode, execute, memory and write-back. It drives the datapath's register-enable and mux-select strobes, and waits on a memory ready handshake. It sits between the instruction register's opcode field and the shared PC/IR/ALUOut/MDR datapath, and uses the opcode macros from `opcodes.v`.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  7  IR[6:0]; stable from the cycle after IR write
- bcond  in  1  ALU branch-compare result, valid in EX
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, i_or_d, pc_source  out  1 each  datapath strobes/selects
- alu_src_a  out  2  0=PC, 1=rs1, 2=old_pc
- alu_src_b  out  2  0=rs2, 1=imm, 2=const 4
- alu_op  out  2  0=ADD, 1=BRANCH compare, 2=FUNCT decode
- wb_sel  out  2  0=ALUOut, 1=MDR, 2=PC
- is_halted  out  1  high in HALT
- state  out  3  current state, for debug

## Operation
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Outputs are combinational from state, opcode and mem_ready. Any output not listed for a state is 0.
- IF:
  - mem_read=1, i_or_d=0, alu_src_a=PC, alu_src_b=4, alu_op=ADD, pc_source=0.
  - Stays in IF while mem_ready=0.
  - On mem_ready=1: ir_write=1 and pc_write=1 (PC←PC+4; the datapath latches old_pc on ir_write), then go to ID.
- ID: alu_src_a=old_pc, alu_src_b=imm, alu_op=ADD, so ALUOut←old_pc+imm. Next state is HALT if opcode==ECALL, otherwise EX.
- EX, by opcode:
  - ARITHMETIC / ARITHMETIC_IMM: alu_src_a=rs1, alu_src_b=rs2/imm, alu_op=FUNCT. Next: WB.
  - LOAD / STORE: alu_src_a=rs1, alu_src_b=imm, alu_op=ADD. Next: MEM.
  - BRANCH: alu_src_a=rs1, alu_src_b=rs2, alu_op=BRANCH, pc_write_cond=1, pc_source=1. The datapath writes PC←ALUOut iff bcond=1. Next: IF.
  - JAL: pc_write=1, pc_source=1, reg_write=1, wb_sel=PC. rd receives old_pc+4, the pre-edge PC value. Next: IF.
  - JALR: alu_src_a=rs1, alu_src_b=imm, alu_op=ADD, pc_source=0, pc_write=1, reg_write=1, wb_sel=PC. Next: IF.
  - Any other opcode: NOP; all strobes 0. Next: IF.
- MEM: i_or_d=1. mem_read=1 for LOAD, mem_write=1 for STORE. Stays in MEM while mem_ready=0. On ready, LOAD goes to WB (the datapath latches MDR) and STORE goes to IF.
- WB: reg_write=1. wb_sel=MDR for LOAD, ALUOut otherwise. Next: IF.
- HALT: is_halted=1 and all other strobes 0. HALT is terminal; only reset leaves it.

## Timing
- Reset value: while reset_n=0, state=IF and every output is 0, including mem_read. After deassertion, IF begins on the first rising edge.
- Reset asserted mid-instruction aborts the instruction immediately. No pending write strobe survives the reset.
- Latency with mem_ready tied high:
  - ALU ops: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH, JAL, JALR: 3 cycles.
  - Each cycle mem_ready stays low adds one cycle to IF or MEM.
- mem_read and mem_write are held stable until the cycle in which mem_ready=1. mem_ready sampled outside IF or MEM is ignored.
- No transition depends on bcond; bcond gates only the datapath's PC write.

## Configuration
- `CTRL_PERF_CNT_EN` defined:
  - Adds outputs cycle_count[31:0] and instret[31:0], both reset to 0.
  - cycle_count increments every cycle not in HALT.
  - instret increments on each transition into IF from EX, MEM or WB.
  - Both wrap at 2^32.
- Undefined: neither port nor counter exists.

## Structure
- Shared package/header holds:
  - state encodings (S_IF … S_HALT);
  - alu_src_a and alu_src_b codes;
  - alu_op codes;
  - wb_sel codes.
- Opcodes come from `opcodes.v`.
- One sub-module, `ctrl_perf_counters`, instantiated only under `CTRL_PERF_CNT_EN`.

## Test plan
- ADD with mem_ready=1: state sequence IF,ID,EX,WB,IF. ir_write and pc_write in cycle 0; reg_write with wb_sel=0 in cycle 3.
- LOAD with mem_ready low for 2 cycles in MEM: stays in MEM for 3 cycles with mem_read=1 and i_or_d=1, then WB with wb_sel=1. Total 7 cycles.
- BRANCH with bcond=0 and then bcond=1: pc_write_cond=1 and pc_source=1 in EX both times. The state returns to IF after 3 cycles.
- JAL: in EX, pc_write=1, pc_source=1, reg_write=1, wb_sel=2. Next state IF.
- ECALL: IF, ID, then HALT with is_halted=1 held for 100 cycles. reset_n low then returns IF with all outputs 0.
- reset_n pulsed low during MEM of a STORE: mem_write drops the same cycle and state=IF.
